// File: rtl/md_unit_if.sv
// Issue/result bundle between the EX-stage hazard logic and the md_unit.
// The master modport issues MD ops; the slave modport is the md_unit itself.
interface md_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, A, B, cancel,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, A, B, cancel,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/md_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO: radix-2 shift-add multiplier and restoring divider.
// Define MD_UNIT_DIV_EN to build the divider; without it DIV/DIVU complete as a 1-cycle no-op.
module md_unit #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    md_unit_if.slave md
);
    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);
    localparam logic [CW-1:0] ONE  = CW'(1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
`ifdef MD_UNIT_DIV_EN
        DIV  = 2'd2,
`endif
        FIX  = 2'd3
    } state_t;

    state_t             state, state_next;
    logic [CW-1:0]      count, count_next;
    logic [2*WIDTH-1:0] acc, acc_next;
    logic [WIDTH-1:0]   opnd, opnd_next;
    logic               neg_q, neg_q_next;
    logic [WIDTH-1:0]   hi_q, hi_next;
    logic [WIDTH-1:0]   lo_q, lo_next;
    logic               busy_q, busy_next;
    logic               done_q, done_next;

    logic               signed_op;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] fix_prod;

`ifdef MD_UNIT_DIV_EN
    logic               neg_r, neg_r_next;
    logic               is_div, is_div_next;
    logic               div_zero, div_zero_next;
    logic [WIDTH:0]     div_diff;
`else
    logic               nop_pend, nop_pend_next;
`endif

    assign md.busy = busy_q;
    assign md.done = done_q;
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;

    // Signed ops run on magnitudes; the sign is restored in FIX.
    assign signed_op = (md.op == OP_MULT) || (md.op == OP_DIV);
    assign a_abs     = (signed_op && md.A[WIDTH-1]) ? -md.A : md.A;
    assign b_abs     = (signed_op && md.B[WIDTH-1]) ? -md.B : md.B;
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    assign fix_prod  = neg_q ? -acc : acc;
`ifdef MD_UNIT_DIV_EN
    assign div_diff  = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            acc      <= '0;
            opnd     <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef MD_UNIT_DIV_EN
            neg_r    <= 1'b0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
`else
            nop_pend <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            count    <= count_next;
            acc      <= acc_next;
            opnd     <= opnd_next;
            neg_q    <= neg_q_next;
            hi_q     <= hi_next;
            lo_q     <= lo_next;
            busy_q   <= busy_next;
            done_q   <= done_next;
`ifdef MD_UNIT_DIV_EN
            neg_r    <= neg_r_next;
            is_div   <= is_div_next;
            div_zero <= div_zero_next;
`else
            nop_pend <= nop_pend_next;
`endif
        end
    end

    // The MUL/DIV states spend one extra cycle at count==WIDTH before FIX, giving WIDTH+2 edges of latency.
    always_comb begin
        state_next    = state;
        count_next    = count;
        acc_next      = acc;
        opnd_next     = opnd;
        neg_q_next    = neg_q;
        hi_next       = hi_q;
        lo_next       = lo_q;
`ifdef MD_UNIT_DIV_EN
        neg_r_next    = neg_r;
        is_div_next   = is_div;
        div_zero_next = div_zero;
        done_next     = 1'b0;
`else
        nop_pend_next = 1'b0;
        done_next     = nop_pend;
`endif

        case (state)
            IDLE: begin
                if (md.start && !md.cancel) begin
                    case (md.op)
                        OP_MTHI: hi_next = md.A;
                        OP_MTLO: lo_next = md.A;
                        OP_MULT, OP_MULTU: begin
                            acc_next    = {{WIDTH{1'b0}}, b_abs};
                            opnd_next   = a_abs;
                            neg_q_next  = signed_op && (md.A[WIDTH-1] ^ md.B[WIDTH-1]);
                            count_next  = '0;
`ifdef MD_UNIT_DIV_EN
                            is_div_next = 1'b0;
`endif
                            state_next  = MUL;
                        end
                        OP_DIV, OP_DIVU: begin
`ifdef MD_UNIT_DIV_EN
                            acc_next      = {{WIDTH{1'b0}}, a_abs};
                            opnd_next     = b_abs;
                            neg_q_next    = signed_op && (md.A[WIDTH-1] ^ md.B[WIDTH-1]);
                            neg_r_next    = signed_op && md.A[WIDTH-1];
                            div_zero_next = (md.B == '0);
                            is_div_next   = 1'b1;
                            count_next    = '0;
                            state_next    = DIV;
`else
                            nop_pend_next = 1'b1;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            MUL: begin
                if (md.cancel) begin
                    state_next = IDLE;
                end else if (count == LAST) begin
                    state_next = FIX;
                end else begin
                    acc_next   = {mul_sum, acc[WIDTH-1:1]};
                    count_next = count + ONE;
                end
            end
`ifdef MD_UNIT_DIV_EN
            DIV: begin
                if (md.cancel) begin
                    state_next = IDLE;
                end else if (count == LAST) begin
                    state_next = FIX;
                end else begin
                    acc_next   = div_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                                 : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                    count_next = count + ONE;
                end
            end
`endif
            FIX: begin
                state_next = IDLE;
                if (!md.cancel) begin
                    done_next = 1'b1;
                    hi_next   = fix_prod[2*WIDTH-1:WIDTH];
                    lo_next   = fix_prod[WIDTH-1:0];
`ifdef MD_UNIT_DIV_EN
                    // A zero divisor leaves |A| as remainder, so neg_r correction restores the original A.
                    if (is_div) begin
                        hi_next = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                        lo_next = div_zero ? {WIDTH{1'b1}}
                                           : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
                    end
`endif
                end
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state != IDLE) && (state_next != IDLE);
    end
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: scoreboard of expected HI/LO pairs checked at each done pulse.
// Divider scenarios follow MD_UNIT_DIV_EN; without it the DIV no-op behaviour is checked instead.
module tb_md_unit;
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    exp_t exp_q[$];

    md_unit_if #(.WIDTH(32)) bus ();

    md_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .md    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mul_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        exp_t   e;
        if (o == OP_MULT) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        p    = sa * sb;
        e.hi = p[63:32];
        e.lo = p[31:0];
        return e;
    endfunction

    function automatic exp_t div_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        exp_t   e;
        if (b == 32'd0) begin
            e.hi = a;
            e.lo = 32'hFFFF_FFFF;
            return e;
        end
        if (o == OP_DIV) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q    = sa / sb;
        r    = sa % sb;
        e.hi = r[31:0];
        e.lo = q[31:0];
        return e;
    endfunction

    // Issues one op at the current cycle and watches up to 60 edges for done; lat stays -1 if none appears.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int inject_at, input logic [2:0] inj_op, input int cancel_at,
                          output int lat, output int busy_cycles,
                          output logic [31:0] got_hi, output logic [31:0] got_lo);
        bus.start = 1'b1;
        bus.op    = o;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        lat         = -1;
        busy_cycles = bus.busy ? 1 : 0;
        for (int n = 1; n <= 60; n++) begin
            if (n - 1 == inject_at) begin
                bus.start = 1'b1;
                bus.op    = inj_op;
                bus.A     = 32'hDEAD_BEEF;
                bus.B     = 32'h0000_0003;
            end
            if (n - 1 == cancel_at) bus.cancel = 1'b1;
            @(posedge clk); #1;
            bus.start  = 1'b0;
            bus.cancel = 1'b0;
            if (bus.busy) busy_cycles++;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
        got_hi = bus.hi;
        got_lo = bus.lo;
    endtask

    task automatic test_reset();
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
        n_cmp++; if (bus.hi !== 32'd0) begin n_bad++; $display("[TB] FAIL reset_hi: got %h expected 0", bus.hi); end
        n_cmp++; if (bus.lo !== 32'd0) begin n_bad++; $display("[TB] FAIL reset_lo: got %h expected 0", bus.lo); end
    endtask

    task automatic test_multu_max();
        int lat, bc;
        logic [31:0] h, l;
        exp_t e;
        exp_q.push_back('{hi: 32'hFFFF_FFFE, lo: 32'h0000_0001});
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, OP_MTHI, -1, lat, bc, h, l);
        e = exp_q.pop_front();
        n_cmp++; if (lat !== 34) begin n_bad++; $display("[TB] FAIL multu_latency: got %0d expected 34", lat); end
        n_cmp++; if (bc !== 33) begin n_bad++; $display("[TB] FAIL multu_busy_cycles: got %0d expected 33", bc); end
        n_cmp++; if (h !== e.hi) begin n_bad++; $display("[TB] FAIL multu_hi: got %h expected %h", h, e.hi); end
        n_cmp++; if (l !== e.lo) begin n_bad++; $display("[TB] FAIL multu_lo: got %h expected %h", l, e.lo); end
        @(posedge clk); #1;
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("[TB] FAIL multu_done_width: got %b expected 0", bus.done); end
    endtask

    task automatic test_mult_patterns();
        logic [31:0] av[5];
        logic [31:0] bv[5];
        logic [2:0]  ov[5];
        int lat, bc;
        logic [31:0] h, l;
        exp_t e;
        av[0] = 32'hFFFF_FFFD; bv[0] = 32'd7;          ov[0] = OP_MULT;
        av[1] = 32'h8000_0000; bv[1] = 32'h8000_0000;  ov[1] = OP_MULT;
        av[2] = $urandom;      bv[2] = $urandom;       ov[2] = OP_MULT;
        av[3] = $urandom;      bv[3] = $urandom;       ov[3] = OP_MULTU;
        av[4] = 32'd0;         bv[4] = $urandom;       ov[4] = OP_MULTU;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(mul_model(ov[i], av[i], bv[i]));
            run_op(ov[i], av[i], bv[i], -1, OP_MTHI, -1, lat, bc, h, l);
            e = exp_q.pop_front();
            n_cmp++; if (lat !== 34) begin n_bad++; $display("[TB] FAIL mul%0d_latency: got %0d expected 34", i, lat); end
            n_cmp++; if (h !== e.hi) begin n_bad++; $display("[TB] FAIL mul%0d_hi: got %h expected %h", i, h, e.hi); end
            n_cmp++; if (l !== e.lo) begin n_bad++; $display("[TB] FAIL mul%0d_lo: got %h expected %h", i, l, e.lo); end
        end
    endtask

`ifdef MD_UNIT_DIV_EN
    task automatic test_div_patterns();
        logic [31:0] av[6];
        logic [31:0] bv[6];
        logic [2:0]  ov[6];
        int lat, bc;
        logic [31:0] h, l;
        exp_t e;
        av[0] = 32'hFFFF_FFF9; bv[0] = 32'd2;          ov[0] = OP_DIV;
        av[1] = 32'd100;       bv[1] = 32'd0;          ov[1] = OP_DIVU;
        av[2] = 32'h8000_0000; bv[2] = 32'hFFFF_FFFF;  ov[2] = OP_DIV;
        av[3] = 32'hFFFF_FFFB; bv[3] = 32'd0;          ov[3] = OP_DIV;
        av[4] = $urandom;      bv[4] = $urandom_range(1, 50000); ov[4] = OP_DIVU;
        av[5] = $urandom;      bv[5] = $urandom;       ov[5] = OP_DIV;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(div_model(ov[i], av[i], bv[i]));
            run_op(ov[i], av[i], bv[i], -1, OP_MTHI, -1, lat, bc, h, l);
            e = exp_q.pop_front();
            n_cmp++; if (lat !== 34) begin n_bad++; $display("[TB] FAIL div%0d_latency: got %0d expected 34", i, lat); end
            n_cmp++; if (h !== e.hi) begin n_bad++; $display("[TB] FAIL div%0d_hi: got %h expected %h", i, h, e.hi); end
            n_cmp++; if (l !== e.lo) begin n_bad++; $display("[TB] FAIL div%0d_lo: got %h expected %h", i, l, e.lo); end
        end
    endtask
`else
    task automatic test_div_nop();
        int lat, bc;
        logic [31:0] h, l;
        exp_t e;
        exp_q.push_back('{hi: bus.hi, lo: bus.lo});
        run_op(OP_DIVU, 32'd9, 32'd3, -1, OP_MTHI, -1, lat, bc, h, l);
        e = exp_q.pop_front();
        n_cmp++; if (lat !== 1) begin n_bad++; $display("[TB] FAIL divnop_latency: got %0d expected 1", lat); end
        n_cmp++; if (bc !== 0) begin n_bad++; $display("[TB] FAIL divnop_busy_cycles: got %0d expected 0", bc); end
        n_cmp++; if (h !== e.hi) begin n_bad++; $display("[TB] FAIL divnop_hi: got %h expected %h", h, e.hi); end
        n_cmp++; if (l !== e.lo) begin n_bad++; $display("[TB] FAIL divnop_lo: got %h expected %h", l, e.lo); end
        @(posedge clk); #1;
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("[TB] FAIL divnop_done_width: got %b expected 0", bus.done); end
    endtask
`endif

    task automatic test_move_and_cancel();
        int lat, bc;
        logic [31:0] h, l;
        exp_t e;
        exp_q.push_back('{hi: 32'h0000_1234, lo: 32'h0000_5678});
        bus.start = 1'b1; bus.op = OP_MTHI; bus.A = 32'h0000_1234;
        @(posedge clk); #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL mthi_busy: got %b expected 0", bus.busy); end
        bus.op = OP_MTLO; bus.A = 32'h0000_5678;
        @(posedge clk); #1;
        bus.start = 1'b0;
        e = exp_q.pop_front();
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL mtlo_busy: got %b expected 0", bus.busy); end
        n_cmp++; if (bus.hi !== e.hi) begin n_bad++; $display("[TB] FAIL mthi_value: got %h expected %h", bus.hi, e.hi); end
        n_cmp++; if (bus.lo !== e.lo) begin n_bad++; $display("[TB] FAIL mtlo_value: got %h expected %h", bus.lo, e.lo); end

        bus.start = 1'b1; bus.op = OP_MTHI; bus.A = 32'h0000_FFFF; bus.cancel = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.cancel = 1'b0;
        n_cmp++; if (bus.hi !== 32'h0000_1234) begin n_bad++; $display("[TB] FAIL idle_cancel_hi: got %h expected 00001234", bus.hi); end

        run_op(OP_MULT, 32'd5, 32'd6, -1, OP_MTHI, 10, lat, bc, h, l);
        n_cmp++; if (lat !== -1) begin n_bad++; $display("[TB] FAIL cancel_no_done: got done at %0d expected none", lat); end
        n_cmp++; if (h !== 32'h0000_1234) begin n_bad++; $display("[TB] FAIL cancel_hi: got %h expected 00001234", h); end
        n_cmp++; if (l !== 32'h0000_5678) begin n_bad++; $display("[TB] FAIL cancel_lo: got %h expected 00005678", l); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL cancel_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_start_while_busy();
        int lat, bc;
        logic [31:0] h, l;
        exp_t e;
        exp_q.push_back(mul_model(OP_MULTU, 32'h0001_0003, 32'h0000_0101));
        run_op(OP_MULTU, 32'h0001_0003, 32'h0000_0101, 5, OP_MTHI, -1, lat, bc, h, l);
        e = exp_q.pop_front();
        n_cmp++; if (lat !== 34) begin n_bad++; $display("[TB] FAIL busy_start_latency: got %0d expected 34", lat); end
        n_cmp++; if (h !== e.hi) begin n_bad++; $display("[TB] FAIL busy_start_hi: got %h expected %h", h, e.hi); end
        n_cmp++; if (l !== e.lo) begin n_bad++; $display("[TB] FAIL busy_start_lo: got %h expected %h", l, e.lo); end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, bc;
        logic [31:0] h, l;
        exp_t e;
        exp_q.push_back(mul_model(OP_MULT, 32'hFFFF_FF00, 32'h0000_0013));
        exp_q.push_back(mul_model(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0));
        run_op(OP_MULT, 32'hFFFF_FF00, 32'h0000_0013, -1, OP_MTHI, -1, lat1, bc, h, l);
        e = exp_q.pop_front();
        n_cmp++; if (h !== e.hi) begin n_bad++; $display("[TB] FAIL b2b_first_hi: got %h expected %h", h, e.hi); end
        n_cmp++; if (l !== e.lo) begin n_bad++; $display("[TB] FAIL b2b_first_lo: got %h expected %h", l, e.lo); end
        run_op(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, -1, OP_MTHI, -1, lat2, bc, h, l);
        e = exp_q.pop_front();
        n_cmp++; if (lat2 !== 34) begin n_bad++; $display("[TB] FAIL b2b_second_latency: got %0d expected 34", lat2); end
        n_cmp++; if (h !== e.hi) begin n_bad++; $display("[TB] FAIL b2b_second_hi: got %h expected %h", h, e.hi); end
        n_cmp++; if (l !== e.lo) begin n_bad++; $display("[TB] FAIL b2b_second_lo: got %h expected %h", l, e.lo); end
    endtask

    task automatic test_reset_mid_op();
        int dones;
        bus.start = 1'b1;
`ifdef MD_UNIT_DIV_EN
        bus.op = OP_DIVU;
`else
        bus.op = OP_MULTU;
`endif
        bus.A = 32'd1000; bus.B = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL midreset_busy: got %b expected 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("[TB] FAIL midreset_done: got %b expected 0", bus.done); end
        n_cmp++; if (bus.hi !== 32'd0) begin n_bad++; $display("[TB] FAIL midreset_hi: got %h expected 0", bus.hi); end
        n_cmp++; if (bus.lo !== 32'd0) begin n_bad++; $display("[TB] FAIL midreset_lo: got %h expected 0", bus.lo); end
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        n_cmp++; if (dones !== 0) begin n_bad++; $display("[TB] FAIL midreset_no_done: got %0d expected 0", dones); end
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.op     = 3'b000;
        bus.A      = 32'd0;
        bus.B      = 32'd0;
        bus.cancel = 1'b0;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        test_multu_max();
        test_mult_patterns();
`ifdef MD_UNIT_DIV_EN
        test_div_patterns();
`else
        test_div_nop();
`endif
        test_move_and_cancel();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_op();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
